rr_arbiter_16: RTL and testbench

//  Round-robin arbiter sharing one downstream resource among 16 requesters.

---
 rtl/rr_arbiter_16.sv | 139 +++++++++++++
 tb/tb_rr_arbiter_16.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a rotating priority pointer and held grants.
// Optional forced release after MAX_HOLD grant cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16 #(
  parameter int NREQ     = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld,
  output logic            timeout
);

  if (NREQ != 16 || IDW != 4 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_arbiter_16: unsupported parameter set");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic            release_req;
  logic            force_rel;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotating scan: first set bit starting at ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + IDW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign release_req = done | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  assign force_rel = ~release_req & (hold_q == 8'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = '0;
`endif
        if (en && found) begin
          gnt_d     = NREQ'(1) << win;
          gnt_id_d  = win;
          gnt_vld_d = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        if (release_req || force_rel) begin
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_id_q + IDW'(1);
          state_d   = IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_d = force_rel;
          hold_d    = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: vector table plus hand sequences, expectations via a queue.
module tb_rr_arbiter_16;
`ifdef ARB_TIMEOUT_EN
  localparam int MAXH = 4;
`else
  localparam int MAXH = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_vld;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        done;
    logic        vld;
    logic [3:0]  id;
    logic        to;
  } vec_t;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  id;
    logic        vld;
    logic        to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  rr_arbiter_16 #(.NREQ(16), .IDW(4), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, expect outputs after the next rising edge.
  task automatic step(input logic e, input logic [15:0] r, input logic d,
                      input logic v, input logic [3:0] id, input logic t);
    exp_t x;
    en = e; req = r; done = d;
    x.vld = v; x.id = id; x.to = t;
    x.gnt = v ? (16'h0001 << id) : 16'h0000;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk("gnt", 32'(gnt), 32'(x.gnt));
    chk("gnt_id", 32'(gnt_id), 32'(x.id));
    chk("gnt_vld", 32'(gnt_vld), 32'(x.vld));
    chk("timeout", 32'(timeout), 32'(x.to));
  endtask

  function automatic vec_t mk(input logic e, input logic [15:0] r, input logic d,
                              input logic v, input logic [3:0] id);
    vec_t t;
    t.en = e; t.req = r; t.done = d; t.vld = v; t.id = id; t.to = 1'b0;
    return t;
  endfunction

  initial begin
    vecs[0]  = mk(1, 16'h0001, 0, 1, 0);
    vecs[1]  = mk(1, 16'h0001, 0, 1, 0);
    vecs[2]  = mk(1, 16'h0001, 1, 0, 0);
    vecs[3]  = mk(1, 16'h0003, 0, 1, 1);
    vecs[4]  = mk(1, 16'h0003, 1, 0, 1);
    vecs[5]  = mk(1, 16'h8001, 0, 1, 15);
    vecs[6]  = mk(1, 16'h8001, 1, 0, 15);
    vecs[7]  = mk(1, 16'h8001, 0, 1, 0);
    vecs[8]  = mk(1, 16'h8001, 1, 0, 0);
    vecs[9]  = mk(1, 16'h8001, 0, 1, 15);
    vecs[10] = mk(1, 16'h8001, 1, 0, 15);
    vecs[11] = mk(1, 16'h8001, 1, 1, 0);
    vecs[12] = mk(1, 16'h8000, 0, 0, 0);
    vecs[13] = mk(1, 16'h8000, 0, 1, 15);
    vecs[14] = mk(1, 16'hFFFF, 0, 1, 15);
    vecs[15] = mk(1, 16'h7FFF, 0, 0, 15);
    vecs[16] = mk(1, 16'h4000, 0, 1, 14);
    vecs[17] = mk(1, 16'h4000, 1, 0, 14);
    vecs[18] = mk(1, 16'h4001, 0, 1, 0);
    vecs[19] = mk(1, 16'h4000, 1, 0, 0);

    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      step(vecs[i].en, vecs[i].req, vecs[i].done, vecs[i].vld, vecs[i].id, vecs[i].to);

    // Async reset in the middle of a grant, checked before any clock edge.
    step(1, 16'h0010, 0, 1, 4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_vld", 32'(gnt_vld), 32'h0);
    chk("async_rst_id", 32'(gnt_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(0, 16'hFFFF, 0, 0, 0, 0);
    step(1, 16'hFFFF, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'hFFFF, 0, 1, 0, 0);
    step(0, 16'hFFFF, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'hFFFF, 0, 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
    step(1, 16'h0004, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h0004, 0, 1, 2, 0);
    step(1, 16'h0004, 0, 0, 2, 1);
    step(1, 16'h000C, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h000C, 0, 1, 3, 0);
    step(1, 16'h000C, 1, 0, 3, 0);
    step(0, 16'h000C, 0, 0, 3, 0);
`else
    step(1, 16'h0004, 0, 1, 2, 0);
    for (int i = 0; i < 300; i++) step(1, 16'h0004, 0, 1, 2, 0);
    step(1, 16'h0004, 1, 0, 2, 0);
    step(1, 16'h000C, 0, 1, 3, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
